// File: rtl/conv_filter_k_if.sv
// Streaming bus for conv_filter_k: kernel-column input with weights/bias and
// a valid/ready result output.
interface conv_filter_k_if #(
  parameter int DATA_W = 16,
  parameter int W_W    = 16,
  parameter int K      = 5,
  parameter int OUT_W  = DATA_W + W_W - 4
);
  logic [DATA_W*K-1:0]  d_in;
  logic [W_W*K*K-1:0]   w_in;
  logic [W_W-1:0]       b_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 win_clr;
  logic [OUT_W-1:0]     d_out;
  logic                 sat;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output d_in, w_in, b_in, in_valid, win_clr, out_ready,
    input  in_ready, d_out, sat, out_valid
  );

  modport slave (
    input  d_in, w_in, b_in, in_valid, win_clr, out_ready,
    output in_ready, d_out, sat, out_valid
  );
endinterface

// File: rtl/conv_filter_k.sv
// KxK convolution window filter: K beats of K pixels, 3-stage pipeline with
// rounding shift, bias and saturation. Optional rectification: CONV_FILTER_RELU_EN.
module conv_filter_k #(
  parameter int DATA_W = 16,
  parameter int W_W    = 16,
  parameter int K      = 5,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = DATA_W + W_W - 4
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_filter_k_if.slave  bus
);

  localparam int P_W   = DATA_W + W_W;
  localparam int ACC_W = DATA_W + W_W + 6;
  localparam int R_W   = ACC_W + 1;
  localparam int CNT_W = $clog2(K);

  localparam logic [ACC_W-1:0] RND = ACC_W'((64'd1 << SHIFT) >> 1);
  localparam logic signed [R_W-1:0] MAX_V = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] MIN_V = ~MAX_V;

  logic                     stall;
  logic                     accept;
  logic [CNT_W-1:0]         beat_cnt_reg;

  logic signed [P_W-1:0]    prod_next [K];
  logic signed [P_W-1:0]    a_prod_reg [K];
  logic                     a_valid_reg;
  logic                     a_last_reg;
  logic signed [W_W-1:0]    a_bias_reg;

  logic signed [ACC_W-1:0]  sum_a;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  c_acc_reg;
  logic signed [W_W-1:0]    c_bias_reg;
  logic                     c_valid_reg;

  logic signed [ACC_W-1:0]  rnd_next;
  logic signed [R_W-1:0]    r_next;
  logic signed [OUT_W-1:0]  res_next;
  logic                     sat_next;

  logic                     out_valid_reg;
  logic signed [OUT_W-1:0]  d_out_reg;
  logic                     sat_reg;

  assign stall         = out_valid_reg && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign accept        = bus.in_valid && !stall && !bus.win_clr;
  assign bus.out_valid = out_valid_reg;
  assign bus.d_out     = d_out_reg;
  assign bus.sat       = sat_reg;

  // One multiplier per row; the weight column is picked by the current beat.
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    logic signed [DATA_W-1:0] pix;
    logic signed [W_W-1:0]    wgt;

    assign pix = bus.d_in[(K-gi)*DATA_W-1 -: DATA_W];

    always_comb begin
      wgt = '0;
      for (int j = 0; j < K; j++) begin
        if (beat_cnt_reg == CNT_W'(j)) begin
          wgt = bus.w_in[(K*K-1-(gi*K+j))*W_W +: W_W];
        end
      end
    end

    assign prod_next[gi] = $signed({{W_W{pix[DATA_W-1]}}, pix})
                         * $signed({{DATA_W{wgt[W_W-1]}}, wgt});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else if (bus.win_clr) begin
      beat_cnt_reg <= '0;
    end else if (accept) begin
      beat_cnt_reg <= (beat_cnt_reg == CNT_W'(K-1)) ? '0 : beat_cnt_reg + 1'b1;
    end
  end

  // Stage A: registered products and the last-beat tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
      a_last_reg  <= 1'b0;
      a_bias_reg  <= '0;
      for (int i = 0; i < K; i++) begin
        a_prod_reg[i] <= '0;
      end
    end else if (bus.win_clr) begin
      a_valid_reg <= 1'b0;
    end else if (!stall) begin
      a_valid_reg <= accept;
      a_last_reg  <= (beat_cnt_reg == CNT_W'(K-1));
      a_bias_reg  <= bus.b_in;
      a_prod_reg  <= prod_next;
    end
  end

  always_comb begin
    sum_a = '0;
    for (int i = 0; i < K; i++) begin
      sum_a = sum_a + ACC_W'(a_prod_reg[i]);
    end
  end

  // Stage B: accumulate; the closing beat hands the total to stage C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      c_acc_reg   <= '0;
      c_bias_reg  <= '0;
      c_valid_reg <= 1'b0;
    end else begin
      if (bus.win_clr) begin
        acc_reg <= '0;
      end else if (!stall && a_valid_reg) begin
        acc_reg <= a_last_reg ? '0 : acc_reg + sum_a;
      end

      if (!stall) begin
        c_valid_reg <= a_valid_reg && a_last_reg && !bus.win_clr;
        if (a_valid_reg && a_last_reg) begin
          c_acc_reg  <= acc_reg + sum_a;
          c_bias_reg <= a_bias_reg;
        end
      end
    end
  end

  // Stage C: round half up, add bias, clip to the output range.
  always_comb begin
    rnd_next = (c_acc_reg + $signed(RND)) >>> SHIFT;
    r_next   = R_W'(rnd_next) + R_W'(c_bias_reg);
    sat_next = 1'b0;
    if (r_next > MAX_V) begin
      res_next = MAX_V[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (r_next < MIN_V) begin
      res_next = MIN_V[OUT_W-1:0];
      sat_next = 1'b1;
    end else begin
      res_next = r_next[OUT_W-1:0];
    end
`ifdef CONV_FILTER_RELU_EN
    if (res_next[OUT_W-1]) begin
      res_next = '0;
      sat_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      d_out_reg     <= '0;
      sat_reg       <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= c_valid_reg;
      if (c_valid_reg) begin
        d_out_reg <= res_next;
        sat_reg   <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_conv_filter_k.sv
// Scoreboard bench for conv_filter_k: two instances (OUT_W=28 and OUT_W=16)
// share one stimulus stream and one output handshake.
module tb_conv_filter_k;

  localparam int DW = 16;
  localparam int WW = 16;
  localparam int K  = 5;
  localparam int SH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_filter_k_if #(.DATA_W(DW), .W_W(WW), .K(K), .OUT_W(28)) bus_a ();
  conv_filter_k_if #(.DATA_W(DW), .W_W(WW), .K(K), .OUT_W(16)) bus_b ();

  conv_filter_k #(.DATA_W(DW), .W_W(WW), .K(K), .SHIFT(SH), .OUT_W(28)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  conv_filter_k #(.DATA_W(DW), .W_W(WW), .K(K), .SHIFT(SH), .OUT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  typedef struct { longint va; bit sa; longint vb; bit sb; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int n_push   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;
  int pix [K][K];   // [beat][row]
  int wt  [K][K];   // [row][beat]
  bit mon_en = 0;
  bit bp_arm = 0;
  bit lat_arm = 0;
  int bp_left = 0;
  longint held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic longint model(input longint acc, input longint bias, input int ow, output bit s);
    longint r, mx, mn;
    r  = ((acc + ((longint'(1) << SH) >> 1)) >>> SH) + bias;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    s  = 1'b0;
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
`ifdef CONV_FILTER_RELU_EN
    if (r < 0) begin r = 0; s = 1'b0; end
`endif
    return r;
  endfunction

  task automatic put_beat(input int j, input int bias, input bit clr);
    logic [DW*K-1:0]  d;
    logic [WW*K*K-1:0] w;
    d = '0;
    w = '0;
    for (int i = 0; i < K; i++) begin
      d[(K-i)*DW-1 -: DW] = DW'(pix[j][i]);
      for (int b = 0; b < K; b++) w[(K*K-1-(i*K+b))*WW +: WW] = WW'(wt[i][b]);
    end
    bus_a.d_in = d;  bus_b.d_in = d;
    bus_a.w_in = w;  bus_b.w_in = w;
    bus_a.b_in = WW'(bias);  bus_b.b_in = WW'(bias);
    bus_a.in_valid = 1'b1;  bus_b.in_valid = 1'b1;
    bus_a.win_clr = clr;    bus_b.win_clr = clr;
  endtask

  task automatic drive_beat(input int j, input int bias);
    int guard;
    bit done;
    guard = 0;
    done = 0;
    @(negedge clk);
    put_beat(j, bias, 1'b0);
    while (!done) begin
      #1;
      if (bus_a.in_ready) done = 1;
      else begin
        guard++;
        if (guard > 200) begin
          check("in_ready_timeout", 0, 1);
          done = 1;
        end else @(negedge clk);
      end
    end
    last_acc_cyc = cyc;
  endtask

  task automatic run_window(input int bias);
    longint acc;
    exp_t e;
    for (int j = 0; j < K; j++) drive_beat(j, bias);
    acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) acc += longint'(pix[j][i]) * longint'(wt[i][j]);
    e.va = model(acc, bias, 28, e.sa);
    e.vb = model(acc, bias, 16, e.sb);
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_a.in_valid = 1'b0;  bus_b.in_valid = 1'b0;
    bus_a.win_clr = 1'b0;   bus_b.win_clr = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic fill(input int p, input int w);
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++) begin
        pix[a][b] = p;
        wt[a][b]  = w;
      end
  endtask

  task automatic fill_rand();
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++) begin
        pix[a][b] = int'($urandom_range(0, 6000)) - 3000;
        wt[a][b]  = int'($urandom_range(0, 6000)) - 3000;
      end
  endtask

  // Output side: owns out_ready, applies backpressure, pops the scoreboard.
  initial begin
    exp_t e;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (bp_left > 0) begin
          check("bp_in_ready", bus_a.in_ready, 0);
          check("bp_hold", $signed(bus_a.d_out), held);
          bp_left--;
        end else if (bp_arm && bus_a.out_valid) begin
          bp_arm  = 0;
          bp_left = 4;
          held    = $signed(bus_a.d_out);
        end
        bus_a.out_ready = (bp_left == 0);
        bus_b.out_ready = (bp_left == 0);
        if (lat_arm && bus_a.out_valid) begin
          lat_arm = 0;
          check("latency", cyc - last_acc_cyc, 3);
        end
        if (bus_a.out_valid && bus_a.out_ready) begin
          check("valid_b", bus_b.out_valid, 1);
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("d_out_28", $signed(bus_a.d_out), e.va);
            check("sat_28", bus_a.sat, e.sa);
            check("d_out_16", $signed(bus_b.d_out), e.vb);
            check("sat_16", bus_b.sat, e.sb);
            $display("out %0d: a=%0d sat=%0d  b=%0d sat=%0d", n_out,
                     $signed(bus_a.d_out), bus_a.sat, $signed(bus_b.d_out), bus_b.sat);
          end
          n_out++;
        end
      end
    end
  end

  initial begin
    int outs_before;
    bus_a.d_in = '0;  bus_b.d_in = '0;
    bus_a.w_in = '0;  bus_b.w_in = '0;
    bus_a.b_in = '0;  bus_b.b_in = '0;
    bus_a.in_valid = 1'b0;  bus_b.in_valid = 1'b0;
    bus_a.win_clr = 1'b0;   bus_b.win_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus_a.in_ready, 1);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_d_out", $signed(bus_a.d_out), 0);
    check("rst_sat", bus_a.sat, 0);
    check("rst_out_valid_b", bus_b.out_valid, 0);
    mon_en = 1;

    // Uniform window plus latency, then the negated pixels.
    fill(256, 256);
    lat_arm = 1;
    run_window(10);
    idle();
    drain();
    check("lat_seen", lat_arm, 0);
    fill(-256, 256);
    run_window(10);
    idle();
    drain();

    // Full-scale operands: clips on the 16-bit output.
    fill(32767, 32767);
    run_window(0);
    idle();
    drain();

    // Rounding boundary around half an LSB.
    fill(0, 0);
    pix[2][3] = 128;
    wt[3][2]  = 1;
    run_window(0);
    pix[2][3] = 127;
    run_window(0);
    idle();
    drain();

    // Back-to-back random windows.
    for (int n = 0; n < 4; n++) begin
      fill_rand();
      run_window(int'($urandom_range(0, 400)) - 200);
    end
    idle();
    drain();

    // Backpressure with a second window queued behind the stalled result.
    bp_arm = 1;
    fill_rand();
    run_window(77);
    fill_rand();
    run_window(-33);
    idle();
    drain();
    check("bp_done", bp_arm, 0);

    // Abort after three beats; the discarded beat rides with win_clr.
    fill_rand();
    for (int j = 0; j < 3; j++) drive_beat(j, 5);
    @(negedge clk);
    put_beat(3, 5, 1'b1);
    run_window(5);
    idle();
    drain();

    // Reset in the middle of a window, then one clean window.
    fill_rand();
    for (int j = 0; j < 4; j++) drive_beat(j, 1);
    idle();
    outs_before = n_out;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus_a.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_no_out", n_out, outs_before);
    run_window(1);
    idle();
    drain();

    repeat (5) @(negedge clk);
    check("out_count", n_out, n_push);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
